// File: rtl/vga_wave_display.sv
// rtl/vga_wave_display.sv - triggered multi-channel waveform renderer for the VGA pixel path
module vga_wave_display #(
    parameter int          CH       = 2,
    parameter int          DW       = 8,
    parameter int          WIN_X0   = 0,
    parameter int          WIN_Y0   = 0,
    parameter int          WIN_W    = 200,
    parameter int          GRID     = 25,
    parameter int          AUTO_TO  = 4096,
    parameter logic [23:0] COL0     = 24'hFF0000,
    parameter logic [23:0] COL1     = 24'h00FF00,
    parameter logic [23:0] COL2     = 24'h0000FF,
    parameter logic [23:0] COL3     = 24'hFFFF00,
    parameter logic [23:0] COL_GRID = 24'h808080,
    parameter logic [23:0] COL_BG   = 24'hBBFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [10:0]      value_x,
    input  logic [10:0]      value_y,
    input  logic             sample_valid,
    input  logic [CH*DW-1:0] sample_data,
    input  logic [DW-1:0]    trig_level,
    input  logic [1:0]       trig_ch,
    input  logic [1:0]       run_mode,
    input  logic             arm,
    output logic [23:0]      rgb,
    output logic [1:0]       state,
    output logic             swapped
);
    localparam int AW = (WIN_W > 1) ? $clog2(WIN_W) : 1;
    localparam int MW = $clog2(2 * WIN_W);
    localparam int CW = $clog2(AUTO_TO + 1);
    localparam int HT = 1 << DW;
    // Guarded divisor so the modulo is well defined even when the grid is off
    localparam int GP = (GRID == 0) ? 1 : GRID;

    localparam logic [1:0] M_NORMAL = 2'd0;
    localparam logic [1:0] M_AUTO   = 2'd1;
    localparam logic [1:0] M_STOP   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t cur_state, nxt_state;

    logic             front;
    logic             shown;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    wr_a;
    logic [MW-1:0]    wr_idx;
    logic [CW-1:0]    auto_cnt;
    logic [DW-1:0]    prev_trig;
    logic             prev_ok;
    logic [DW-1:0]    trig_cur;
    logic             frame_start;
    logic             trig_hit;
    logic             enter_armed;
    logic             wr_en;
    logic             wr_first;
    logic             do_swap;

    logic [CH*DW-1:0] mem [0:2*WIN_W-1];

    // Render stage-1 signals
    logic [10:0]      col_c;
    logic [10:0]      row_c;
    logic             x_in;
    logic             y_in;
    logic             in_win_c;
    logic             grid_c;
    logic [AW-1:0]    rd_col;
    logic [MW-1:0]    rd_idx;

    logic             s1_in;
    logic             s1_grid;
    logic             s1_first;
    logic             s1_shown;
    logic [DW-1:0]    s1_row;
    logic [CH*DW-1:0] s1_cur;
    logic [CH*DW-1:0] s1_prev;

    // Render stage-2 signals
    logic [CH-1:0]    lit;
    logic [DW-1:0]    sr_a;
    logic [DW-1:0]    sr_b;
    logic [DW-1:0]    sr_lo;
    logic [DW-1:0]    sr_hi;
    logic [23:0]      pix;

    function automatic logic [23:0] ch_col(input int k);
        case (k)
            0:       ch_col = COL0;
            1:       ch_col = COL1;
            2:       ch_col = COL2;
            default: ch_col = COL3;
        endcase
    endfunction

    assign state       = cur_state;
    assign frame_start = (value_x == 11'd0) && (value_y == 11'd0);

    // Pick the trigger channel; out-of-range selections fall back to channel 0
    always_comb begin
        trig_cur = sample_data[DW-1:0];
        for (int k = 0; k < CH; k++) begin
            if (trig_ch == 2'(k)) trig_cur = sample_data[k*DW +: DW];
        end
    end

    // Rising crossing of the threshold, or a forced trigger once AUTO has waited long enough
    always_comb begin
        trig_hit = sample_valid &&
                   ((prev_ok && (prev_trig < trig_level) && (trig_cur >= trig_level)) ||
                    ((run_mode == M_AUTO) && (auto_cnt == CW'(AUTO_TO))));
    end

    // Capture FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_state <= S_IDLE;
        else        cur_state <= nxt_state;
    end

    // Capture FSM next state and per-cycle control strobes
    always_comb begin
        nxt_state   = cur_state;
        enter_armed = 1'b0;
        wr_en       = 1'b0;
        wr_first    = 1'b0;
        do_swap     = 1'b0;
        case (cur_state)
            S_IDLE: begin
                if (arm) begin
                    nxt_state   = S_ARMED;
                    enter_armed = 1'b1;
                end
            end
            S_ARMED: begin
                if (run_mode == M_STOP) begin
                    nxt_state = S_IDLE;
                end else if (trig_hit) begin
                    nxt_state = S_CAPTURE;
                    wr_en     = 1'b1;
                    wr_first  = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (sample_valid) begin
                    wr_en = 1'b1;
                    if (wr_addr == AW'(WIN_W - 1)) nxt_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (frame_start) begin
                    do_swap = 1'b1;
                    if ((run_mode == M_NORMAL) || (run_mode == M_AUTO)) begin
                        nxt_state   = S_ARMED;
                        enter_armed = 1'b1;
                    end else begin
                        nxt_state = S_IDLE;
                    end
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // Capture bookkeeping: bank flip, trigger history, AUTO timeout and write pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front     <= 1'b0;
            shown     <= 1'b0;
            swapped   <= 1'b0;
            prev_ok   <= 1'b0;
            prev_trig <= '0;
            auto_cnt  <= '0;
            wr_addr   <= '0;
        end else begin
            swapped <= do_swap;
            if (do_swap) begin
                front <= ~front;
                shown <= 1'b1;
            end
            if (enter_armed) begin
                prev_ok  <= 1'b0;
                auto_cnt <= '0;
            end else if ((cur_state == S_ARMED) && sample_valid) begin
                prev_ok   <= 1'b1;
                prev_trig <= trig_cur;
                if (auto_cnt != CW'(AUTO_TO)) auto_cnt <= auto_cnt + 1'b1;
            end
            if (wr_first) wr_addr <= AW'(1);
            else if (wr_en) wr_addr <= (wr_addr == AW'(WIN_W - 1)) ? '0 : wr_addr + 1'b1;
        end
    end

    // Captures always land in the bank that is not on screen
    always_comb begin
        wr_a   = wr_first ? '0 : wr_addr;
        wr_idx = front ? MW'(wr_a) : MW'(WIN_W) + MW'(wr_a);
    end

    // Sample memory write port
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= sample_data;
    end

    // Stage 1: window test done before subtracting so left/top of window cannot wrap
    always_comb begin
        col_c    = value_x - 11'(WIN_X0);
        row_c    = value_y - 11'(WIN_Y0);
        x_in     = (value_x >= 11'(WIN_X0)) && ({1'b0, col_c} < 12'(WIN_W));
        y_in     = (value_y >= 11'(WIN_Y0)) && ({1'b0, row_c} < 12'(HT));
        in_win_c = x_in && y_in;
        grid_c   = (GRID != 0) && in_win_c && !col_c[0] && !row_c[0] &&
                   (((col_c % 11'(GP)) == 11'd0) || ((row_c % 11'(GP)) == 11'd0));
        rd_col   = x_in ? col_c[AW-1:0] : '0;
        rd_idx   = front ? MW'(WIN_W) + MW'(rd_col) : MW'(rd_col);
    end

    // Stage 1 flags, registered alongside the memory read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_in    <= 1'b0;
            s1_grid  <= 1'b0;
            s1_first <= 1'b0;
            s1_shown <= 1'b0;
            s1_row   <= '0;
        end else begin
            s1_in    <= in_win_c;
            s1_grid  <= grid_c;
            s1_first <= (col_c == 11'd0);
            s1_shown <= shown;
            s1_row   <= row_c[DW-1:0];
        end
    end

    // One read per pixel; the previous read is kept as the sample for column-1
    always_ff @(posedge clk) begin
        s1_cur  <= mem[rd_idx];
        s1_prev <= s1_cur;
    end

    // Stage 2: segment hit test per channel, then priority colour select
    always_comb begin
        lit   = '0;
        sr_a  = '0;
        sr_b  = '0;
        sr_lo = '0;
        sr_hi = '0;
        for (int k = 0; k < CH; k++) begin
            sr_a   = ~s1_cur[k*DW +: DW];
            sr_b   = s1_first ? sr_a : ~s1_prev[k*DW +: DW];
            sr_lo  = (sr_a < sr_b) ? sr_a : sr_b;
            sr_hi  = (sr_a < sr_b) ? sr_b : sr_a;
            lit[k] = (s1_row >= sr_lo) && (s1_row <= sr_hi);
        end
        pix = s1_grid ? COL_GRID : COL_BG;
        for (int k = CH - 1; k >= 0; k--) begin
            if (lit[k] && s1_shown) pix = ch_col(k);
        end
        if (!s1_in) pix = 24'h000000;
    end

    // Stage 2 output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rgb <= 24'h000000;
        else        rgb <= pix;
    end

endmodule

// File: tb/tb_vga_wave_display.sv
// tb/tb_vga_wave_display.sv - directed self-checking bench for vga_wave_display
module tb_vga_wave_display;
    localparam int X0 = 8;
    localparam int Y0 = 4;
    localparam int W  = 200;
    localparam int NX = X0 + W + 2;
    localparam logic [23:0] C0 = 24'hFF0000;
    localparam logic [23:0] C1 = 24'h00FF00;
    localparam logic [23:0] CG = 24'h808080;
    localparam logic [23:0] CB = 24'hBBFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] value_x = 11'd1000;
    logic [10:0] value_y = 11'd1000;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = '0;
    logic [7:0]  trig_level = 8'd128;
    logic [1:0]  trig_ch = 2'd0;
    logic [1:0]  run_mode = 2'd0;
    logic        arm = 1'b0;
    logic [23:0] rgb;
    logic [1:0]  state;
    logic        swapped;

    int checks = 0;
    int failures = 0;
    logic [23:0] line [0:NX-1];

    vga_wave_display #(
        .CH(2), .DW(8), .WIN_X0(X0), .WIN_Y0(Y0), .WIN_W(W), .GRID(25), .AUTO_TO(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .value_x(value_x), .value_y(value_y),
        .sample_valid(sample_valid), .sample_data(sample_data), .trig_level(trig_level),
        .trig_ch(trig_ch), .run_mode(run_mode), .arm(arm), .rgb(rgb), .state(state),
        .swapped(swapped)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        sample_data  = {b, a};
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic pulse_arm;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic frame(output logic sw);
        value_x = 11'd0;
        value_y = 11'd0;
        @(negedge clk);
        sw = swapped;
        value_x = 11'd1000;
        value_y = 11'd1000;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Scan one row left to right; line[x] receives the pixel for value_x == x
    task automatic scan_row(input int r);
        value_y = 11'(Y0 + r);
        for (int i = 0; i < NX + 2; i++) begin
            if (i >= 2) line[i-2] = rgb;
            value_x = (i < NX) ? 11'(i) : 11'd1000;
            @(negedge clk);
        end
        value_x = 11'd1000;
        value_y = 11'd1000;
    endtask

    task automatic test_reset;
        logic sw;
        logic [23:0] exp;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (swapped !== 1'b0) begin failures++; $display("FAIL reset_swapped got=%0d exp=0", swapped); end
        checks++; if (rgb !== 24'h0) begin failures++; $display("FAIL reset_rgb got=%h exp=000000", rgb); end
        rst_n = 1'b1;
        @(negedge clk);
        frame(sw);
        checks++; if (sw !== 1'b0) begin failures++; $display("FAIL idle_no_swap got=%0d exp=0", sw); end
        for (int r = 0; r < 3; r++) begin
            scan_row(r);
            for (int x = 0; x < NX; x++) begin
                if (x < X0 || x >= X0 + W) exp = 24'h0;
                else if (((x - X0) % 2 == 0) && (r % 2 == 0) && (((x - X0) % 25 == 0) || (r % 25 == 0))) exp = CG;
                else exp = CB;
                checks++;
                if (line[x] !== exp) begin failures++; $display("FAIL blank_row%0d_x%0d got=%h exp=%h", r, x, line[x], exp); end
            end
        end
        scan_row(256);
        for (int x = 0; x < NX; x += 23) begin
            checks++;
            if (line[x] !== 24'h0) begin failures++; $display("FAIL below_window_x%0d got=%h exp=000000", x, line[x]); end
        end
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL idle_state got=%0d exp=0", state); end
    endtask

    task automatic test_ramp;
        logic sw;
        logic [23:0] exp;
        run_mode = 2'd0; trig_level = 8'd128; trig_ch = 2'd0;
        pulse_arm;
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL ramp_armed got=%0d exp=1", state); end
        for (int i = 0; i < 327; i++) send(8'(i % 256), 8'd128);
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL ramp_capturing got=%0d exp=2", state); end
        send(8'd71, 8'd128);
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL ramp_hold got=%0d exp=3", state); end
        frame(sw);
        checks++; if (sw !== 1'b1) begin failures++; $display("FAIL ramp_swapped got=%0d exp=1", sw); end
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL ramp_rearmed got=%0d exp=1", state); end
        scan_row(127);
        for (int x = 0; x < NX; x++) begin
            if (x < X0 || x >= X0 + W) exp = 24'h0;
            else if (x == X0 || x == X0 + 1 || x == X0 + 128) exp = C0;
            else exp = C1;
            checks++;
            if (line[x] !== exp) begin failures++; $display("FAIL ramp_row127_x%0d got=%h exp=%h", x, line[x], exp); end
        end
        scan_row(123);
        checks++; if (line[X0+5] !== C0) begin failures++; $display("FAIL ramp_r123_c5 got=%h exp=%h", line[X0+5], C0); end
        checks++; if (line[X0+6] !== CB) begin failures++; $display("FAIL ramp_r123_c6 got=%h exp=%h", line[X0+6], CB); end
    endtask

    task automatic test_step;
        logic sw;
        run_mode = 2'd0; trig_level = 8'd5; trig_ch = 2'd3;
        send(8'd0, 8'd0);
        send(8'd10, 8'd0);
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL step_trig got=%0d exp=2", state); end
        for (int i = 0; i < 49; i++) send(8'd10, 8'd0);
        for (int i = 0; i < 149; i++) send(8'd200, 8'd0);
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL step_capturing got=%0d exp=2", state); end
        send(8'd200, 8'd0);
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL step_hold got=%0d exp=3", state); end
        scan_row(127);
        checks++; if (line[X0] !== C0) begin failures++; $display("FAIL no_tear_before_swap got=%h exp=%h", line[X0], C0); end
        frame(sw);
        checks++; if (sw !== 1'b1) begin failures++; $display("FAIL step_swapped got=%0d exp=1", sw); end
        scan_row(127);
        checks++; if (line[X0] !== CB) begin failures++; $display("FAIL step_r127_c0 got=%h exp=%h", line[X0], CB); end
        scan_row(55);
        checks++; if (line[X0+50] !== C0) begin failures++; $display("FAIL step_r55_c50 got=%h exp=%h", line[X0+50], C0); end
        checks++; if (line[X0+51] !== C0) begin failures++; $display("FAIL step_r55_c51 got=%h exp=%h", line[X0+51], C0); end
        checks++; if (line[X0+49] !== CB) begin failures++; $display("FAIL step_r55_c49 got=%h exp=%h", line[X0+49], CB); end
        scan_row(54);
        checks++; if (line[X0+50] !== CG) begin failures++; $display("FAIL step_r54_c50 got=%h exp=%h", line[X0+50], CG); end
        checks++; if (line[X0+51] !== CB) begin failures++; $display("FAIL step_r54_c51 got=%h exp=%h", line[X0+51], CB); end
        scan_row(150);
        checks++; if (line[X0+50] !== C0) begin failures++; $display("FAIL step_r150_c50 got=%h exp=%h", line[X0+50], C0); end
        checks++; if (line[X0+52] !== CG) begin failures++; $display("FAIL step_r150_c52 got=%h exp=%h", line[X0+52], CG); end
        scan_row(244);
        checks++; if (line[X0+49] !== CB) begin failures++; $display("FAIL step_r244_c49 got=%h exp=%h", line[X0+49], CB); end
        checks++; if (line[X0+50] !== C0) begin failures++; $display("FAIL step_r244_c50 got=%h exp=%h", line[X0+50], C0); end
        scan_row(245);
        checks++; if (line[X0+48] !== C0) begin failures++; $display("FAIL step_r245_c48 got=%h exp=%h", line[X0+48], C0); end
        checks++; if (line[X0+49] !== C0) begin failures++; $display("FAIL step_r245_c49 got=%h exp=%h", line[X0+49], C0); end
        checks++; if (line[X0+50] !== C0) begin failures++; $display("FAIL step_r245_c50 got=%h exp=%h", line[X0+50], C0); end
        scan_row(246);
        checks++; if (line[X0+49] !== CB) begin failures++; $display("FAIL step_r246_c49 got=%h exp=%h", line[X0+49], CB); end
        checks++; if (line[X0+50] !== CG) begin failures++; $display("FAIL step_r246_c50 got=%h exp=%h", line[X0+50], CG); end
    endtask

    task automatic test_auto;
        logic sw;
        do_reset;
        run_mode = 2'd1; trig_level = 8'd128; trig_ch = 2'd0;
        pulse_arm;
        for (int i = 0; i < 16; i++) send(8'd0, 8'd0);
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL auto_16_still_armed got=%0d exp=1", state); end
        send(8'd0, 8'd0);
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL auto_17_forced got=%0d exp=2", state); end
        for (int i = 0; i < 198; i++) send(8'd0, 8'd0);
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL auto_capturing got=%0d exp=2", state); end
        send(8'd0, 8'd0);
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL auto_hold got=%0d exp=3", state); end
        frame(sw);
        checks++; if (sw !== 1'b1) begin failures++; $display("FAIL auto_swapped got=%0d exp=1", sw); end
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL auto_rearmed got=%0d exp=1", state); end
        scan_row(255);
        checks++; if (line[X0+10] !== C0) begin failures++; $display("FAIL auto_r255_c10 got=%h exp=%h", line[X0+10], C0); end
        scan_row(254);
        checks++; if (line[X0+10] !== CB) begin failures++; $display("FAIL auto_r254_c10 got=%h exp=%h", line[X0+10], CB); end
    endtask

    task automatic test_single;
        logic sw;
        do_reset;
        run_mode = 2'd2; trig_level = 8'd5; trig_ch = 2'd0;
        pulse_arm;
        send(8'd0, 8'd0);
        send(8'd10, 8'd0);
        for (int i = 0; i < 198; i++) send(8'd10, 8'd0);
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL single_capturing got=%0d exp=2", state); end
        send(8'd10, 8'd0);
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL single_hold got=%0d exp=3", state); end
        frame(sw);
        checks++; if (sw !== 1'b1) begin failures++; $display("FAIL single_swapped got=%0d exp=1", sw); end
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL single_idle got=%0d exp=0", state); end
        scan_row(245);
        checks++; if (line[X0+30] !== C0) begin failures++; $display("FAIL single_r245_c30 got=%h exp=%h", line[X0+30], C0); end
        send(8'd0, 8'd0);
        for (int i = 0; i < 5; i++) send(8'd200, 8'd0);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL single_stays_idle got=%0d exp=0", state); end
        frame(sw);
        checks++; if (sw !== 1'b0) begin failures++; $display("FAIL single_no_second_swap got=%0d exp=0", sw); end
        scan_row(245);
        checks++; if (line[X0+30] !== C0) begin failures++; $display("FAIL single_frozen got=%h exp=%h", line[X0+30], C0); end
        pulse_arm;
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL single_rearm got=%0d exp=1", state); end
        run_mode = 2'd3;
        @(negedge clk);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL stop_in_armed got=%0d exp=0", state); end
    endtask

    task automatic test_reset_in_capture;
        run_mode = 2'd0; trig_level = 8'd5; trig_ch = 2'd0;
        pulse_arm;
        send(8'd0, 8'd0);
        send(8'd10, 8'd0);
        send(8'd10, 8'd0);
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL rc_capturing got=%0d exp=2", state); end
        rst_n = 1'b0;
        #1;
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL rc_async_state got=%0d exp=0", state); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        scan_row(245);
        checks++; if (line[X0+30] !== CB) begin failures++; $display("FAIL rc_traces_hidden got=%h exp=%h", line[X0+30], CB); end
        checks++; if (line[X0-1] !== 24'h0) begin failures++; $display("FAIL left_of_window got=%h exp=000000", line[X0-1]); end
        checks++; if (line[X0+W] !== 24'h0) begin failures++; $display("FAIL right_of_window got=%h exp=000000", line[X0+W]); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_ramp;
        test_step;
        test_auto;
        test_single;
        test_reset_in_capture;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_wave_display.md
# vga_wave_display

Multi-channel, triggered waveform renderer for the VGA path: captures `WIN_W` samples per channel into a double-buffered sample memory and draws them as connected traces inside a rectangular window, with a dotted grid and per-channel colours. Sits between the sample source and the VGA timing generator, consuming the generator's `value_x`/`value_y` pixel coordinates and producing the registered 24-bit `rgb` pixel. Bank swaps happen only at frame start, so a displayed frame never tears.

## Interface
Parameters:
- `CH`, 2: number of channels (1..4).
- `DW`, 8: sample width; trace height is `2**DW` pixels.
- `WIN_X0`, 0 / `WIN_Y0`, 0: window top-left pixel.
- `WIN_W`, 200: samples per channel, equal to window width in pixels.
- `GRID`, 25: grid pitch in pixels; 0 disables the grid.
- `AUTO_TO`, 4096: AUTO-mode trigger timeout in valid samples.
- `COL0`, 24'hFF0000 / `COL1`, 24'h00FF00 / `COL2`, 24'h0000FF / `COL3`, 24'hFFFF00: trace colours.
- `COL_GRID`, 24'h808080 / `COL_BG`, 24'hBBFFFF: grid and background colours.

Ports:
- `clk` in 1: single system and pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `value_x` in 11: current pixel column.
- `value_y` in 11: current pixel row.
- `sample_valid` in 1: one-cycle strobe; `sample_data` is valid this cycle.
- `sample_data` in `CH*DW`: channel k occupies bits `[k*DW +: DW]`.
- `trig_level` in `DW`: trigger threshold.
- `trig_ch` in 2: channel used for triggering (values ≥ `CH` are treated as 0).
- `run_mode` in 2: 0 NORMAL, 1 AUTO, 2 SINGLE, 3 STOP.
- `arm` in 1: one-cycle start request.
- `rgb` out 24: registered pixel colour.
- `state` out 2: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 HOLD.
- `swapped` out 1: one-cycle pulse when a new capture becomes visible.

## Operation
- Memory: 2 banks × `CH` × `WIN_W` × `DW`. Capture writes the back bank; display reads the front bank. `front` resets to 0. `shown` (front bank holds valid data) resets to 0.
- Capture FSM:
  - IDLE: `arm` → ARMED (a capture that was armed but not yet completed is discarded).
  - ARMED: tracks the previous trigger-channel sample (the previous sample is marked invalid on entry). A trigger occurs on a valid sample where `prev < trig_level` and `cur >= trig_level`; the trigger sample itself is written to address 0. In AUTO mode, after `AUTO_TO` valid samples without a trigger, the next valid sample forces the trigger. → CAPTURE.
  - CAPTURE: each `sample_valid` writes all channels at address `wr_addr` and increments it. The write at `WIN_W-1` → HOLD.
  - HOLD: on the frame-start cycle (`value_x==0 && value_y==0`), toggle `front`, set `shown`, pulse `swapped`. Then NORMAL/AUTO → ARMED; SINGLE/STOP → IDLE.
  - `run_mode==3` in ARMED → IDLE; CAPTURE and HOLD complete normally.
  - `arm` is ignored outside IDLE.
- Render, with `col = value_x - WIN_X0` and `row = value_y - WIN_Y0`:
  - The pixel is inside the window when `0 ≤ col < WIN_W` and `0 ≤ row < 2**DW`.
  - Screen row of sample d is `2**DW-1-d`. Channel k lights the pixel when `row` lies between the screen rows of samples `col-1` and `col` inclusive. At `col==0`, only the point at sample 0 is used.
  - Grid: in window, `GRID!=0`, and (`col%GRID==0` or `row%GRID==0`), with both `col` and `row` even (dotted).
  - Priority: ch0 > ch1 > ch2 > ch3 > grid > background. Traces are suppressed while `shown==0`. Outside the window, `rgb = 24'h000000`.
- Arithmetic: coordinates are 11-bit unsigned. Out-of-window detection must not wrap when `value_x < WIN_X0`.

## Timing
- `rgb` is valid 2 clocks after the `value_x`/`value_y` it corresponds to. Stage 1: compute address and in-window/grid flags, issue the memory read. Stage 2: compare and colour select. The latency is fixed regardless of window membership.
- The previous sample (`col-1`) is held from the preceding read, so there is one read per pixel; `value_x` must advance by 1 per clock inside the window.
- Reset values: `rgb=0`, `state=IDLE`, `swapped=0`, `front=0`, `shown=0`, `wr_addr=0`, AUTO counter 0. An asynchronous reset mid-capture abandons the capture.
- The swap takes effect for pixels whose stage-1 occurs on or after the cycle after frame start. HOLD may last multiple frames only if the frame-start coordinate is never presented.
- `sample_valid` on the same cycle as the frame-start swap in HOLD is dropped.

## Test plan
- Reset, then scan a full frame → `rgb` equals `COL_BG`/`COL_GRID` inside the window and 0 outside; `state=0`; no `swapped` pulse.
- NORMAL, `trig_level=128`, ch0 ramp 0..255 repeating, `arm` → trigger on the 127→128 sample; after 200 samples `state=3`; at the next frame start `swapped=1` and `state=1`; the pixel at column 0, row 127 is `COL0`.
- Ch0 step from 10 to 200 between samples 49 and 50 → column 50 is lit `COL0` for rows 55..245 inclusive; column 49 is lit only at row 245.
- AUTO, constant 0 input, `AUTO_TO=16` → trigger forced on the 17th valid sample; capture completes.
- SINGLE → after one swap `state=0`; further samples do not change the display until the next `arm`.
- Ch0 and ch1 on the same pixel → `COL0` wins. `value_x=WIN_X0-1` → 0, not a wrapped in-window pixel. Reset asserted in CAPTURE → `state=0`, `shown=0`.
